// File: rtl/egr_pfs_dpb_stall_ctrl.sv
// -----------------------------------------------------------------------------
// egr_pfs_dpb_stall_ctrl
//
// PFS-side consumer of the DPB stall. It registers dpb_stall once and uses it
// to gate fetch requests leaving a small skid FIFO. The FIFO keeps accepting
// requests from the PFS arbiter while the stall is in effect, until it fills.
// A RUN/STALL/WDOG state machine counts stalled cycles and raises a sticky
// watchdog error when a stall is held longer than the configured limit.
//
// Ports:
//   cclk, rst_n       core clock, synchronous active-low reset
//   dpb_stall         stall request from the DPB
//   cfg_stall_en      1 = honour dpb_stall, 0 = ignore it
//   cfg_wdog_limit    max consecutive stalled cycles (0 = watchdog off)
//   clr_stats         clears stall_cycle_cnt and wdog_err
//   up_req_*          valid/ready request input from the PFS arbiter
//   dn_req_*          valid/ready request output to the fetch pipeline
//   stall_active      FSM is in STALL or WDOG
//   stall_cycle_cnt   saturating count of cycles spent in STALL/WDOG
//   wdog_err          sticky watchdog error
// -----------------------------------------------------------------------------
module egr_pfs_dpb_stall_ctrl #(
  parameter int SKID_DEPTH = 4,
  parameter int REQ_W      = 24,
  parameter int CNT_W      = 32,
  parameter int WDOG_W     = 16
) (
  input  logic              cclk,
  input  logic              rst_n,
  input  logic              dpb_stall,
  input  logic              cfg_stall_en,
  input  logic [WDOG_W-1:0] cfg_wdog_limit,
  input  logic              clr_stats,
  input  logic              up_req_valid,
  input  logic [REQ_W-1:0]  up_req_data,
  output logic              up_req_ready,
  output logic              dn_req_valid,
  output logic [REQ_W-1:0]  dn_req_data,
  input  logic              dn_req_ready,
  output logic              stall_active,
  output logic [CNT_W-1:0]  stall_cycle_cnt,
  output logic              wdog_err
);

  localparam int PTR_W = $clog2(SKID_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(SKID_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_WDOG  = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [WDOG_W-1:0] sat_inc_wdog(input logic [WDOG_W-1:0] v);
    return (&v) ? v : v + WDOG_W'(1);
  endfunction

  logic [REQ_W-1:0]  mem [SKID_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  logic              stall_q;
  logic              eff_stall;
  state_t            state;
  logic [WDOG_W-1:0] wdog_cnt;

  assign eff_stall = stall_q & cfg_stall_en;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Ready is held low during reset so nothing is accepted into a FIFO that
  // is being cleared in the same cycle.
  assign up_req_ready = rst_n & ~full;
  assign push         = up_req_valid & up_req_ready;

  // The head is only presented from registered state, so a request written
  // this cycle cannot appear downstream before the next cycle.
  assign dn_req_valid = ~empty & ~eff_stall;
  assign dn_req_data  = empty ? '0 : mem[rd_ptr];
  assign pop          = dn_req_valid & dn_req_ready;

  assign stall_active = (state != ST_RUN);

  // Skid FIFO storage (payload only, no reset needed)
  always_ff @(posedge cclk) begin
    if (push) begin
      mem[wr_ptr] <= up_req_data;
    end
  end

  // Skid FIFO pointers and occupancy
  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Stall register, FSM, watchdog and statistics
  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      stall_q         <= 1'b0;
      state           <= ST_RUN;
      wdog_cnt        <= '0;
      wdog_err        <= 1'b0;
      stall_cycle_cnt <= '0;
    end else begin
      stall_q <= dpb_stall;

      case (state)
        ST_RUN: begin
          if (eff_stall) begin
            state    <= ST_STALL;
            wdog_cnt <= WDOG_W'(1);
          end else begin
            wdog_cnt <= '0;
          end
        end
        ST_STALL: begin
          if (!eff_stall) begin
            state    <= ST_RUN;
            wdog_cnt <= '0;
          end else if ((cfg_wdog_limit != '0) && (wdog_cnt == cfg_wdog_limit)) begin
            state <= ST_WDOG;
          end else begin
            wdog_cnt <= sat_inc_wdog(wdog_cnt);
          end
        end
        ST_WDOG: begin
          if (!eff_stall) begin
            state    <= ST_RUN;
            wdog_cnt <= '0;
          end
        end
        default: begin
          state    <= ST_RUN;
          wdog_cnt <= '0;
        end
      endcase

      // Clear has priority over both the sticky set and the increment.
      if (clr_stats) begin
        wdog_err <= 1'b0;
      end else if (state == ST_WDOG) begin
        wdog_err <= 1'b1;
      end

      if (clr_stats) begin
        stall_cycle_cnt <= '0;
      end else if (state != ST_RUN) begin
        stall_cycle_cnt <= sat_inc_cnt(stall_cycle_cnt);
      end
    end
  end

endmodule

// File: doc/egr_pfs_dpb_stall_ctrl.md
Name: egr_pfs_dpb_stall_ctrl

Overview:
PFS-side consumer of the DPB stall signal. It registers the DPB stall and gates issue of packet fetch requests toward the fetch pipeline. A small skid FIFO absorbs requests still arriving from the PFS arbiter while a stall is in effect. It also keeps stall statistics and a watchdog that flags a stall held too long. It sits between the PFS arbiter output and the fetch request pipeline.

Parameters:
SKID_DEPTH, 4, skid FIFO entries (power of 2, >=2)
REQ_W, 24, fetch request payload width
CNT_W, 32, stall cycle counter width
WDOG_W, 16, watchdog limit/counter width

Ports:
cclk  in  1  core clock
rst_n  in  1  synchronous active-low reset
dpb_stall  in  1  stall from DPB (dpb modport output)
cfg_stall_en  in  1  1 = honour stall; 0 = ignore stall
cfg_wdog_limit  in  WDOG_W  max consecutive stall cycles; 0 = watchdog disabled
clr_stats  in  1  clears stall_cycle_cnt and wdog_err
up_req_valid  in  1  request from PFS arbiter
up_req_data  in  REQ_W  request payload
up_req_ready  out  1  block accepts request
dn_req_valid  out  1  request to fetch pipeline
dn_req_data  out  REQ_W  request payload
dn_req_ready  in  1  fetch pipeline accepts
stall_active  out  1  FSM not in RUN
stall_cycle_cnt  out  CNT_W  saturating count of stalled cycles
wdog_err  out  1  sticky watchdog error

Behaviour:
- Reset (rst_n=0 at a cclk edge):
  - FIFO empty; FSM=RUN; stall_q=0; counters 0; wdog_err=0.
  - dn_req_valid=0, dn_req_data=0, stall_active=0.
  - up_req_ready is forced to 0 while rst_n=0.
  - Reset mid-operation discards all FIFO contents.
- stall_q is dpb_stall registered once. eff_stall = stall_q & cfg_stall_en.
- Skid FIFO:
  - up_req_ready = !full. Push on up_req_valid & up_req_ready.
  - No push when full, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when neither full nor empty: count unchanged.
  - No combinational bypass. A request pushed into an empty FIFO reaches dn_req_valid on the next cycle at the earliest (min latency 1).
- Output:
  - dn_req_valid = !empty & !eff_stall. dn_req_data is the FIFO head.
  - Pop on dn_req_valid & dn_req_ready.
  - While dn_req_valid=1 & dn_req_ready=0, dn_req_data is held stable.
  - dn_req_valid may drop without a handshake when eff_stall rises; this is the defined flow control and downstream tolerates it.
  - Request order is preserved.
- FSM states: RUN, STALL, WDOG.
  - RUN -> STALL when eff_stall=1.
  - STALL -> RUN when eff_stall=0.
  - STALL -> WDOG when cfg_wdog_limit!=0 & wdog_cnt==cfg_wdog_limit & eff_stall=1.
  - WDOG -> RUN when eff_stall=0.
  - stall_active is 1 in STALL and WDOG.
- wdog_cnt:
  - Cleared in RUN.
  - Increments by 1 each cycle in STALL, saturating at all-ones. Its value is 1 on the first STALL cycle.
- wdog_err:
  - Set in the cycle after entering WDOG.
  - Sticky until clr_stats=1.
  - If clr_stats and the set condition occur together, clear wins.
- stall_cycle_cnt:
  - Increments each cycle the FSM is in STALL or WDOG; saturates at all-ones.
  - clr_stats=1 sets it to 0; clear wins over increment.
- cfg_stall_en=0 while in STALL or WDOG: eff_stall drops, so the FSM returns to RUN next cycle and the FIFO drains normally.
- dpb_stall pulse of 1 cycle: exactly 1 cycle of dn_req_valid suppression, occurring 1 cycle after the pulse.

Test Plan:
- Reset then 8 back-to-back requests with dn_req_ready=1, no stall -> 8 requests out in order; first dn_req_valid 1 cycle after first push; stall_cycle_cnt=0.
- Assert dpb_stall for 10 cycles with continuous up traffic -> dn_req_valid=0 for 10 cycles starting 1 cycle late; FIFO fills to 4 and up_req_ready=0; stall_cycle_cnt=10; no request lost or reordered after release.
- cfg_wdog_limit=5, stall held 20 cycles -> STALL->WDOG after 5 stalled cycles; wdog_err=1 from the 7th stalled cycle; it stays 1 after stall release until clr_stats.
- cfg_stall_en=0, dpb_stall=1 constant -> traffic flows unaffected; stall_active=0; counters stay 0.
- FIFO full with dn_req_ready toggling every cycle and dn_req_ready=0 mid-stall -> dn_req_data stable while valid & !ready; push and pop in the same cycle keep the count; never more than 4 entries.
- Assert rst_n=0 for 1 cycle with 3 entries buffered and FSM=STALL -> next cycle FIFO empty, FSM=RUN, all outputs 0, wdog_err=0.
